// File: rtl/fetch_stage.sv
// Instruction fetch stage for a five-stage MIPS-style pipeline.
//
// Holds the fetch PC, selects the next PC (reset vector, exception handler,
// stall hold, eret return, D-stage redirect, or sequential pc+4), flags
// address-error-on-load (AdEL) for the fetch address, squashes the fetched
// instruction under eret, and counts instructions accepted into D.
//
// Ports:
//   clk          in   1   clock, all state updates on rising edge
//   reset        in   1   synchronous, active-low reset
//   Req          in   1   exception/interrupt request from CP0
//   stall        in   1   hazard stall, hold PC
//   eret_D       in   1   eret in D stage
//   EPC          in  32   return address from CP0
//   redirect     in   1   D-stage taken branch / jump
//   redirect_pc  in  32   redirect target
//   is_jump_D    in   1   D-stage instruction is a branch or jump
//   instr_in     in  32   instruction word read from IM at pc
//   pc           out 32   current fetch address (IM address)
//   instr_out    out 32   instruction to F/D register
//   EXCcode_out  out  5   fetch exception code
//   Delay_out    out  1   fetched instruction is in a delay slot
//   fetch_cnt    out 32   instructions accepted into D
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        stall,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        is_jump_D,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr_out,
  output logic [4:0]  EXCcode_out,
  output logic        Delay_out,
  output logic [31:0] fetch_cnt
);

  localparam logic [31:0] ResetPc   = 32'h0000_3000;
  localparam logic [31:0] HandlerPc = 32'h0000_4180;
  localparam logic [31:0] ImLo      = 32'h0000_3000;
  localparam logic [31:0] ImHi      = 32'h0000_6FFF;
  localparam logic [4:0]  ExcAdEL   = 5'd4;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        adel;
  logic        squash;

  // eret has no delay slot: the instruction behind it must not issue.
  assign squash = eret_D & ~stall;

  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < ImLo) || (pc_q > ImHi);

  always_comb begin
    instr_out   = instr_in;
    EXCcode_out = 5'd0;
    Delay_out   = is_jump_D;
    if (squash) begin
      instr_out   = 32'd0;
      EXCcode_out = 5'd0;
      Delay_out   = 1'b0;
    end else if (adel) begin
      instr_out   = 32'd0;
      EXCcode_out = ExcAdEL;
    end
  end

  // AdEL does not influence the next PC; CP0 reacts later via Req.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (Req) begin
      pc_d = HandlerPc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eret_D) begin
      pc_d = EPC;
    end else if (redirect) begin
      pc_d = redirect_pc;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (!Req && !stall && !squash) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= ResetPc;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stimulus, all compared against a rule-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, Req, stall, eret_D, redirect, is_jump_D;
  logic [31:0] EPC, redirect_pc, instr_in;
  logic [31:0] pc, instr_out, fetch_cnt;
  logic [4:0]  EXCcode_out;
  logic        Delay_out;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .Req         (Req),
    .stall       (stall),
    .eret_D      (eret_D),
    .EPC         (EPC),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .is_jump_D   (is_jump_D),
    .instr_in    (instr_in),
    .pc          (pc),
    .instr_out   (instr_out),
    .EXCcode_out (EXCcode_out),
    .Delay_out   (Delay_out),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] m_pc, m_cnt;
  bit          m_valid = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle, then the registers
  // just after the rising edge.
  task automatic step();
    bit          bad_addr, squashed;
    logic [31:0] nxt_pc, nxt_cnt;
    @(negedge clk);
    if (m_valid) begin
      bad_addr = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFF);
      squashed = eret_D && !stall;
      check_eq("pc_mid", pc, m_pc);
      check_eq("cnt_mid", fetch_cnt, m_cnt);
      check_eq("instr", instr_out, (squashed || bad_addr) ? 32'd0 : instr_in);
      check_eq("exc", {27'd0, EXCcode_out}, (!squashed && bad_addr) ? 32'd4 : 32'd0);
      check_eq("delay", {31'd0, Delay_out}, (!squashed && is_jump_D) ? 32'd1 : 32'd0);
    end
    if (!reset) begin
      nxt_pc  = 32'h3000;
      nxt_cnt = 0;
    end else begin
      if (Req)           nxt_pc = 32'h4180;
      else if (stall)    nxt_pc = m_pc;
      else if (eret_D)   nxt_pc = EPC;
      else if (redirect) nxt_pc = redirect_pc;
      else               nxt_pc = m_pc + 4;
      nxt_cnt = (!Req && !stall && !eret_D) ? m_cnt + 1 : m_cnt;
    end
    @(posedge clk);
    #1;
    m_pc    = nxt_pc;
    m_cnt   = nxt_cnt;
    m_valid = (reset === 1'b0) || m_valid;
    if (m_valid) begin
      check_eq("pc", pc, m_pc);
      check_eq("cnt", fetch_cnt, m_cnt);
    end
  endtask

  task automatic idle_inputs();
    reset = 1; Req = 0; stall = 0; eret_D = 0; redirect = 0; is_jump_D = 0;
    EPC = 32'h3000; redirect_pc = 32'h3000;
  endtask

  task automatic jump_to(input logic [31:0] target);
    redirect = 1; redirect_pc = target;
    step();
    redirect = 0;
  endtask

  initial begin
    idle_inputs();
    instr_in = 32'h1234_5678;

    // Cold reset for two cycles, then free running.
    reset = 0;
    step();
    step();
    check_eq("reset_pc", pc, 32'h3000);
    check_eq("reset_cnt", fetch_cnt, 32'd0);
    reset = 1;
    repeat (3) step();
    check_eq("seq_pc", pc, 32'h300C);
    check_eq("seq_cnt", fetch_cnt, 32'd3);

    // Redirect with delay slot.
    jump_to(32'h3010);
    redirect = 1; redirect_pc = 32'h3100; is_jump_D = 1;
    step();
    redirect = 0; is_jump_D = 0;
    check_eq("redir_pc", pc, 32'h3100);

    // Stall hold, then Req wins over stall.
    jump_to(32'h3020);
    stall = 1;
    repeat (3) step();
    check_eq("stall_pc", pc, 32'h3020);
    Req = 1;
    step();
    Req = 0; stall = 0;
    check_eq("req_pc", pc, 32'h4180);

    // Address errors: misaligned, above range, and the last legal word.
    jump_to(32'h3102);
    step();
    jump_to(32'h7000);
    step();
    jump_to(32'h6FFC);
    step();

    // eret squash; redirect loses to EPC; Req beats both.
    jump_to(32'h3000);
    eret_D = 1; EPC = 32'h3040; redirect = 1; redirect_pc = 32'h3100; is_jump_D = 1;
    step();
    check_eq("eret_pc", pc, 32'h3040);
    Req = 1;
    step();
    Req = 0; eret_D = 0; redirect = 0; is_jump_D = 0;
    check_eq("eret_req_pc", pc, 32'h4180);

    // Counter wrap.
    dut.fetch_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step();
    check_eq("wrap_cnt", fetch_cnt, 32'd0);

    // Reset asserted mid-stall with a pending exception.
    step();
    stall = 1; Req = 1; eret_D = 1; reset = 0;
    step();
    idle_inputs();
    check_eq("warm_reset_pc", pc, 32'h3000);
    check_eq("warm_reset_cnt", fetch_cnt, 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 99) >= 3);
      Req         = ($urandom_range(0, 99) < 5);
      stall       = ($urandom_range(0, 99) < 20);
      eret_D      = ($urandom_range(0, 99) < 8);
      redirect    = ($urandom_range(0, 99) < 20);
      is_jump_D   = ($urandom_range(0, 99) < 30);
      instr_in    = $urandom;
      redirect_pc = ($urandom_range(0, 9) == 0) ? $urandom
                                                : 32'h3000 + ($urandom_range(0, 4095) << 2);
      EPC         = ($urandom_range(0, 9) == 0) ? $urandom
                                                : 32'h3000 + ($urandom_range(0, 4095) << 2);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low; sampled on rising clk.
REQ-003 SHALL have: Req  in  1  exception/interrupt request from CP0; redirect to handler.
REQ-004 SHALL have: stall  in  1  hazard stall; hold PC (F/D register write-enable is ~stall).
REQ-005 SHALL have: eret_D  in  1  eret in D stage.
REQ-006 SHALL have: EPC  in  32  return address from CP0.
REQ-007 SHALL have: redirect  in  1  D-stage branch taken / j / jal / jr / jalr.
REQ-008 SHALL have: redirect_pc  in  32  target for redirect.
REQ-009 SHALL have: is_jump_D  in  1  D-stage instr is a branch or jump (any outcome).
REQ-010 SHALL have: instr_in  in  32  instruction word from IM at address pc.
REQ-011 SHALL have: pc  out  32  current fetch address (also IM address).
REQ-012 SHALL have: instr_out  out  32  instruction to F/D register.
REQ-013 SHALL have: EXCcode_out  out  5  fetch exception code.
REQ-014 SHALL have: Delay_out  out  1  fetched instr is in a delay slot.
REQ-015 SHALL have: fetch_cnt  out  32  count of instructions accepted into D.

Function
REQ-016 pc SHALL be a register; all other outputs combinational from pc, instr_in and inputs, except fetch_cnt (register).
REQ-017 Next-pc priority SHALL be: reset low -> 0x0000_3000; Req -> 0x0000_4180; stall -> hold; eret_D -> EPC; redirect -> redirect_pc; else pc+4.
REQ-018 Req SHALL override stall, eret_D and redirect in the same cycle.
REQ-019 pc+4 SHALL be 32-bit modulo; no carry out kept.
REQ-020 AdEL SHALL be flagged when pc[1:0] != 0 or pc outside 0x0000_3000..0x0000_6FFF inclusive.
REQ-021 On AdEL: EXCcode_out = 5'd4, instr_out = 0; else EXCcode_out = 0, instr_out = instr_in.
REQ-022 On eret_D=1 and stall=0 (eret has no delay slot): current F instr SHALL be squashed: instr_out = 0, EXCcode_out = 0, Delay_out = 0; squash overrides AdEL.
REQ-023 Delay_out SHALL equal is_jump_D when not squashed (F holds the delay slot of the D-stage branch/jump).
REQ-024 AdEL SHALL not alter next-pc selection; the pc advances normally and the exception travels down the pipe until CP0 raises Req.
REQ-025 fetch_cnt SHALL increment by 1 each cycle with reset high, Req=0, stall=0 and no squash; wraps 0xFFFF_FFFF -> 0.
REQ-026 redirect and eret_D both high SHALL resolve to EPC.
REQ-027 Under stall, outputs SHALL remain stable as long as instr_in is stable.

Reset
REQ-028 With reset=0 at a rising edge: pc = 0x0000_3000, fetch_cnt = 0, regardless of all other inputs.
REQ-029 Reset SHALL be fully synchronous; asserting reset between edges SHALL not change pc before the next edge.
REQ-030 Reset mid-stall or mid-exception SHALL yield the same state as a cold reset.

Verification
REQ-031 Reset low 2 cycles, release, 3 free cycles, no stall -> pc 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt 0,1,2,3.
REQ-032 pc=0x3010, redirect=1, redirect_pc=0x3100, is_jump_D=1 -> Delay_out=1 this cycle; next pc 0x3100.
REQ-033 stall=1 for 3 cycles at pc=0x3020 -> pc held 0x3020, fetch_cnt unchanged; Req=1 during stall -> next pc 0x4180.
REQ-034 redirect_pc=0x3102 -> next cycle EXCcode_out=4, instr_out=0; redirect_pc=0x7000 -> same; pc=0x6FFC -> no exception.
REQ-035 eret_D=1, EPC=0x3040, redirect=1 -> instr_out=0, Delay_out=0, fetch_cnt unchanged; next pc 0x3040; with Req=1 also -> next pc 0x4180.
REQ-036 Force fetch_cnt to 0xFFFF_FFFF, one unstalled cycle -> 0x0000_0000.
